// File: rtl/tbus_link_ctrl.sv
// Half-duplex link controller for one node on a shared bus of inverting tri-state buffers.
// It pre-inverts transmit data, times the drive and turnaround windows, and captures words that peers strobe onto the bus.
module tbus_link_ctrl #(
  parameter int W         = 8,
  parameter int DRIVE_CYC = 2,
  parameter int TURN_CYC  = 1
) (
  input  logic         CLK,
  input  logic         R,
  input  logic         grant,
  input  logic         tx_valid,
  input  logic [W-1:0] tx_data,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [W-1:0] rx_data,
  output logic         bus_en,
  output logic [W-1:0] bus_a,
  output logic         bus_stb_a,
  input  logic [W-1:0] bus_in,
  input  logic         bus_stb_in,
  output logic         err,
  output logic [1:0]   dbg_state
);

  localparam int MAX_CYC = (DRIVE_CYC > TURN_CYC) ? DRIVE_CYC : TURN_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             stb_q;
  logic [W-1:0]     tx_word;
  logic             rx_start;
  logic             tx_go;

  // tx handshake: tx_data is taken on an edge where the controller is in IDLE and
  // grant & tx_valid hold while the bus is quiet. tx_ready pulses for one cycle after
  // that edge. The core keeps tx_valid and tx_data steady until it sees the pulse.
  assign rx_start  = bus_stb_in & ~stb_q;
  assign tx_go     = grant & tx_valid & ~bus_stb_in;
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state     <= IDLE;
      cnt       <= '0;
      stb_q     <= 1'b0;
      tx_word   <= '0;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      bus_en    <= 1'b0;
      bus_a     <= '1;
      bus_stb_a <= 1'b1;
      err       <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      stb_q    <= bus_stb_in;
      case (state)
        IDLE: begin
          if (rx_start) begin
            rx_data  <= bus_in;
            rx_valid <= 1'b1;
          end else if (tx_go) begin
            // The buffers invert, so drive the complement to put true data on the bus.
            tx_word   <= tx_data;
            tx_ready  <= 1'b1;
            bus_a     <= ~tx_data;
            bus_stb_a <= 1'b0;
            bus_en    <= 1'b1;
            cnt       <= '0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == CNT_W'(DRIVE_CYC - 1)) begin
            if ((bus_in != tx_word) || !bus_stb_in) begin
              err <= 1'b1;
            end
            bus_en    <= 1'b0;
            bus_stb_a <= 1'b1;
            cnt       <= '0;
            state     <= TURN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TURN: begin
          if (cnt == CNT_W'(TURN_CYC - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          bus_en    <= 1'b0;
          bus_stb_a <= 1'b1;
          cnt       <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbus_link_ctrl.sv
// Bench for tbus_link_ctrl: it models the inverting bus buffers and a peer node.
// Expected values come from the timing rules of the link.
module tb_tbus_link_ctrl;
  localparam int W         = 8;
  localparam int DRIVE_CYC = 2;
  localparam int TURN_CYC  = 1;
  localparam int PERIOD    = 1 + DRIVE_CYC + TURN_CYC;

  logic         CLK = 1'b0;
  logic         R = 1'b0;
  logic         grant = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_ready;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         bus_en;
  logic [W-1:0] bus_a;
  logic         bus_stb_a;
  logic [W-1:0] bus_in;
  logic         bus_stb_in;
  logic         err;
  logic [1:0]   dbg_state;

  logic         peer_stb = 1'b0;
  logic [W-1:0] peer_data = '0;
  logic [W-1:0] fault_mask = '0;
  logic         drop_stb = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  // The buffer row inverts A while enabled; otherwise the peer owns the bus.
  assign bus_in     = bus_en ? (~bus_a ^ fault_mask) : peer_data;
  assign bus_stb_in = bus_en ? (~bus_stb_a & ~drop_stb) : peer_stb;

  always #5 CLK = ~CLK;

  tbus_link_ctrl #(.W(W), .DRIVE_CYC(DRIVE_CYC), .TURN_CYC(TURN_CYC)) dut (
    .CLK(CLK), .R(R), .grant(grant), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .bus_en(bus_en),
    .bus_a(bus_a), .bus_stb_a(bus_stb_a), .bus_in(bus_in), .bus_stb_in(bus_stb_in),
    .err(err), .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [20:0] got, want;
    R = 1'b0;
    repeat (2) @(negedge CLK);
    got  = {bus_en, bus_stb_a, bus_a, tx_ready, rx_valid, rx_data, err};
    want = {1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};
    n_checks++;
    if (got !== want) $display("FAIL reset_values: got %h want %h", got, want);
    else n_pass++;
    R = 1'b1;
    step();
    got = {bus_en, bus_stb_a, bus_a, tx_ready, rx_valid, rx_data, err};
    n_checks++;
    if (got !== want) $display("FAIL idle_after_release: got %h want %h", got, want);
    else n_pass++;
  endtask

  task automatic test_single_tx();
    logic [10:0] got;
    grant = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    step();
    got = {tx_ready, bus_en, bus_stb_a, bus_a};
    n_checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 8'h5A}) $display("FAIL tx_first_drive: got %h want %h", got, {1'b1, 1'b1, 1'b0, 8'h5A});
    else n_pass++;
    tx_valid = 1'b0;
    step();
    got = {tx_ready, bus_en, bus_stb_a, bus_a};
    n_checks++;
    if (got !== {1'b0, 1'b1, 1'b0, 8'h5A}) $display("FAIL tx_second_drive: got %h want %h", got, {1'b0, 1'b1, 1'b0, 8'h5A});
    else n_pass++;
    step();
    n_checks++;
    if ({tx_ready, bus_en, bus_stb_a, err} !== 4'b0010) $display("FAIL tx_turn: got %b want 0010", {tx_ready, bus_en, bus_stb_a, err});
    else n_pass++;
    step();
    n_checks++;
    if ({tx_ready, bus_en, err} !== 3'b000) $display("FAIL tx_idle: got %b want 000", {tx_ready, bus_en, err});
    else n_pass++;
    grant = 1'b0;
  endtask

  task automatic test_contention();
    grant = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5; fault_mask = 8'h01;
    step();
    tx_valid = 1'b0;
    step();
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_early: got %b want 0", err);
    else n_pass++;
    step();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_data_mismatch: got %b want 1", err);
    else n_pass++;
    fault_mask = '0;
    step();
    tx_valid = 1'b1; tx_data = 8'h5A;
    step();
    tx_valid = 1'b0;
    repeat (4) step();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else n_pass++;
    R = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_cleared_by_reset: got %b want 0", err);
    else n_pass++;
    @(negedge CLK);
    R = 1'b1;
    step();
    drop_stb = 1'b1; tx_valid = 1'b1; tx_data = 8'h0F;
    step();
    tx_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_missing_strobe: got %b want 1", err);
    else n_pass++;
    drop_stb = 1'b0; grant = 1'b0;
    R = 1'b0;
    @(negedge CLK);
    R = 1'b1;
    step();
  endtask

  task automatic test_rx();
    int pulses;
    grant = 1'b0; tx_valid = 1'b0;
    peer_stb = 1'b1; peer_data = 8'h3C;
    pulses = 0;
    step();
    n_checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) $display("FAIL rx_capture: got %h want %h", {rx_valid, rx_data}, {1'b1, 8'h3C});
    else n_pass++;
    if (rx_valid) pulses++;
    repeat (2) begin
      step();
      if (rx_valid) pulses++;
    end
    peer_stb = 1'b0; peer_data = 8'h00;
    repeat (2) begin
      step();
      if (rx_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 1) $display("FAIL rx_single_pulse: got %0d pulses want 1", pulses);
    else n_pass++;
    n_checks++;
    if (rx_data !== 8'h3C) $display("FAIL rx_held: got %h want 3c", rx_data);
    else n_pass++;
  endtask

  task automatic test_rx_vs_tx();
    peer_stb = 1'b1; peer_data = 8'hC3;
    grant = 1'b1; tx_valid = 1'b1; tx_data = 8'h11;
    step();
    n_checks++;
    if ({rx_valid, rx_data, tx_ready, bus_en} !== {1'b1, 8'hC3, 1'b0, 1'b0})
      $display("FAIL rx_wins: got %h want %h", {rx_valid, rx_data, tx_ready, bus_en}, {1'b1, 8'hC3, 1'b0, 1'b0});
    else n_pass++;
    step();
    n_checks++;
    if ({tx_ready, bus_en} !== 2'b00) $display("FAIL tx_wait_strobe: got %b want 00", {tx_ready, bus_en});
    else n_pass++;
    peer_stb = 1'b0; peer_data = 8'h00;
    step();
    n_checks++;
    if ({tx_ready, bus_en, bus_a} !== {1'b1, 1'b1, 8'hEE}) $display("FAIL tx_retry: got %h want %h", {tx_ready, bus_en, bus_a}, {1'b1, 1'b1, 8'hEE});
    else n_pass++;
    tx_valid = 1'b0; grant = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[2];
    logic [W-1:0] want_a;
    logic         exp_rdy, exp_en;
    int           idx;
    words[0] = 8'h12; words[1] = 8'hED;
    idx = 0;
    grant = 1'b1; tx_valid = 1'b1; tx_data = words[0];
    for (int i = 0; i < 10; i++) begin
      step();
      // A word accepted at sample k owns the bus for DRIVE_CYC samples; the next accept is PERIOD later.
      exp_rdy = ((i % PERIOD) == 0) && (i / PERIOD < 2);
      exp_en  = ((i % PERIOD) < DRIVE_CYC) && (i / PERIOD < 2);
      want_a  = exp_en ? ~words[i / PERIOD] : bus_a;
      n_checks++;
      if ({tx_ready, bus_en, bus_a} !== {exp_rdy, exp_en, want_a})
        $display("FAIL b2b_cycle%0d: got %h want %h", i, {tx_ready, bus_en, bus_a}, {exp_rdy, exp_en, want_a});
      else n_pass++;
      if (tx_ready) begin
        idx++;
        if (idx < 2) tx_data = words[idx];
        else tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0; grant = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    logic [20:0] got, want;
    grant = 1'b1; tx_valid = 1'b1; tx_data = 8'h77;
    step();
    tx_valid = 1'b0;
    step();
    n_checks++;
    if (bus_en !== 1'b1) $display("FAIL mid_drive_en: got %b want 1", bus_en);
    else n_pass++;
    #2 R = 1'b0;
    #1;
    got  = {bus_en, bus_stb_a, bus_a, tx_ready, rx_valid, rx_data, err};
    want = {1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};
    n_checks++;
    if (got !== want) $display("FAIL async_reset_mid_drive: got %h want %h", got, want);
    else n_pass++;
    @(negedge CLK);
    R = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({bus_en, tx_ready} !== 2'b00) $display("FAIL post_reset_quiet%0d: got %b want 00", i, {bus_en, tx_ready});
      else n_pass++;
    end
    tx_valid = 1'b1; tx_data = 8'h03;
    step();
    n_checks++;
    if ({tx_ready, bus_en, bus_a} !== {1'b1, 1'b1, 8'hFC}) $display("FAIL post_reset_tx: got %h want %h", {tx_ready, bus_en, bus_a}, {1'b1, 1'b1, 8'hFC});
    else n_pass++;
    tx_valid = 1'b0; grant = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_random_tx();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_word;
    logic         accept, exp_en;
    int           c_last;
    for (int k = 0; k < 8; k++) exp_q.push_back(W'($urandom));
    c_last = -100;
    cur_word = '0;
    for (int e = 0; e < 100; e++) begin
      grant = ($urandom_range(0, 3) != 0);
      if (!tx_valid && exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        tx_valid = 1'b1;
        tx_data  = exp_q[0];
      end
      accept = tx_valid && grant && (e >= c_last + PERIOD);
      if (accept) begin
        c_last   = e;
        cur_word = exp_q.pop_front();
      end
      step();
      exp_en = (e - c_last) < DRIVE_CYC;
      n_checks++;
      if ({tx_ready, bus_en, err} !== {accept, exp_en, 1'b0})
        $display("FAIL rand_tx_ctl e%0d: got %b want %b", e, {tx_ready, bus_en, err}, {accept, exp_en, 1'b0});
      else n_pass++;
      if (exp_en) begin
        n_checks++;
        if (bus_a !== ~cur_word) $display("FAIL rand_tx_data e%0d: got %h want %h", e, bus_a, ~cur_word);
        else n_pass++;
      end
      if (accept) tx_valid = 1'b0;
    end
    tx_valid = 1'b0; grant = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_random_rx();
    logic         prev_stb, exp_valid;
    logic [W-1:0] last_rx;
    grant = 1'b0; tx_valid = 1'b0; peer_stb = 1'b0;
    step();
    prev_stb = 1'b0;
    last_rx  = '0;
    for (int e = 0; e < 50; e++) begin
      peer_stb  = (e == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      peer_data = W'($urandom);
      exp_valid = peer_stb && !prev_stb;
      if (exp_valid) last_rx = peer_data;
      prev_stb = peer_stb;
      step();
      n_checks++;
      if ({rx_valid, rx_data} !== {exp_valid, last_rx})
        $display("FAIL rand_rx e%0d: got %h want %h", e, {rx_valid, rx_data}, {exp_valid, last_rx});
      else n_pass++;
    end
    peer_stb = 1'b0; peer_data = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_contention();
    test_rx();
    test_rx_vs_tx();
    test_back_to_back();
    test_reset_mid_drive();
    test_random_tx();
    test_random_rx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
